// File: rtl/mmio_bus_router.sv
// CPU data-port router: address-prefix decode onto NUM_REGIONS slaves, latency-matched
// read return, per-region write protection and bus-fault capture/counting.
module mmio_bus_router #(
   parameter int                               NUM_REGIONS = 8,
   parameter int                               DATA_W      = 32,
   parameter int                               ADDR_W      = 32,
   parameter int                               PREFIX_W    = 12,
   parameter logic [NUM_REGIONS*PREFIX_W-1:0]  REGION_BASE = 96'h008_007_006_005_004_003_002_001,
   parameter int                               RD_LAT      = 1,
   parameter logic [NUM_REGIONS-1:0]           WR_PROT     = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ADDR_W-1:0]             cpu_addr,
   input  logic [DATA_W-1:0]             cpu_wrdata,
   input  logic [2:0]                    cpu_memop,
   input  logic                          cpu_we,
   input  logic                          cpu_re,
   output logic [DATA_W-1:0]             cpu_rddata,
   output logic                          cpu_rdvalid,
   output logic [ADDR_W-PREFIX_W-1:0]    slv_addr,
   output logic [DATA_W-1:0]             slv_wrdata,
   output logic [2:0]                    slv_memop,
   output logic [NUM_REGIONS-1:0]        slv_we,
   input  logic [NUM_REGIONS*DATA_W-1:0] slv_rddata,
   input  logic                          fault_clr,
   output logic                          fault_valid,
   output logic [ADDR_W-1:0]             fault_addr,
   output logic                          fault_is_write,
   output logic [15:0]                   fault_cnt
);
   localparam int OFF_W = ADDR_W - PREFIX_W;
   localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

   logic [PREFIX_W-1:0] prefix;
   logic                hit;
   logic [IDX_W-1:0]    win;
   logic                rd_issue;
   logic                fault_ev;

   assign prefix = cpu_addr[ADDR_W-1 -: PREFIX_W];

   // Descending scan so the lowest matching index is the last one written.
   always_comb begin
      hit = 1'b0;
      win = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (prefix == REGION_BASE[i*PREFIX_W +: PREFIX_W]) begin
            hit = 1'b1;
            win = IDX_W'(i);
         end
      end
   end

   assign slv_addr   = cpu_addr[OFF_W-1:0];
   assign slv_wrdata = cpu_wrdata;
   assign slv_memop  = cpu_memop;

   always_comb begin
      slv_we = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         slv_we[i] = ~rst & cpu_we & hit & (win == IDX_W'(i)) & ~WR_PROT[i];
      end
   end

   // A simultaneous store and load is a store only.
   assign rd_issue = cpu_re & ~cpu_we;
   assign fault_ev = (rd_issue & ~hit) | (cpu_we & (~hit | WR_PROT[win]));

   logic [RD_LAT-1:0] tag_vld_q;
   logic [RD_LAT-1:0] tag_miss_q;
   logic [IDX_W-1:0]  tag_idx_q [RD_LAT];
   logic [DATA_W-1:0] rd_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld_q <= '0;
      end else begin
         tag_vld_q[0] <= rd_issue;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      tag_miss_q[0] <= ~hit;
      tag_idx_q[0]  <= win;
      for (int i = 1; i < RD_LAT; i++) begin
         tag_miss_q[i] <= tag_miss_q[i-1];
         tag_idx_q[i]  <= tag_idx_q[i-1];
      end
   end

   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (tag_idx_q[RD_LAT-1] == IDX_W'(i)) rd_sel = slv_rddata[i*DATA_W +: DATA_W];
      end
   end

   assign cpu_rdvalid = tag_vld_q[RD_LAT-1];
   assign cpu_rddata  = (tag_vld_q[RD_LAT-1] & ~tag_miss_q[RD_LAT-1]) ? rd_sel : '0;

   logic              fault_valid_q, fault_valid_d;
   logic [ADDR_W-1:0] fault_addr_q,  fault_addr_d;
   logic              fault_wr_q,    fault_wr_d;
   logic [15:0]       fault_cnt_q,   fault_cnt_d;

   // A clear in the same cycle as a new fault re-arms capture for that fault.
   always_comb begin
      fault_valid_d = fault_valid_q & ~fault_clr;
      fault_addr_d  = fault_addr_q;
      fault_wr_d    = fault_wr_q;
      if (fault_ev && (!fault_valid_q || fault_clr)) begin
         fault_valid_d = 1'b1;
         fault_addr_d  = cpu_addr;
         fault_wr_d    = cpu_we;
      end
      fault_cnt_d = fault_clr ? 16'h0000 : fault_cnt_q;
      if (fault_ev && (fault_cnt_d != 16'hFFFF)) fault_cnt_d = fault_cnt_d + 16'h0001;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_valid_q <= 1'b0;
         fault_addr_q  <= '0;
         fault_wr_q    <= 1'b0;
         fault_cnt_q   <= '0;
      end else begin
         fault_valid_q <= fault_valid_d;
         fault_addr_q  <= fault_addr_d;
         fault_wr_q    <= fault_wr_d;
         fault_cnt_q   <= fault_cnt_d;
      end
   end

   assign fault_valid    = fault_valid_q;
   assign fault_addr     = fault_addr_q;
   assign fault_is_write = fault_wr_q;
   assign fault_cnt      = fault_cnt_q;
endmodule

// File: tb/tb_mmio_bus_router.sv
// Bench for mmio_bus_router: three instances (RD_LAT 1/3/2, region 2 write-protected on
// the RD_LAT=3 one) driven in lockstep and checked against a cycle-indexed reference model.
module tb_mmio_bus_router;
   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  addr, wdata;
   logic [2:0]   memop;
   logic         we, re, clr;
   logic [31:0]  slv_val [8];
   logic [255:0] slv_rd;

   logic [31:0] rdd  [3];
   logic        rdv  [3];
   logic [19:0] saddr[3];
   logic [31:0] swd  [3];
   logic [2:0]  smop [3];
   logic [7:0]  swe  [3];
   logic        fv   [3];
   logic [31:0] fa   [3];
   logic        fw   [3];
   logic [15:0] fc   [3];

   always #5 clk = ~clk;

   always_comb begin
      slv_rd = '0;
      for (int i = 0; i < 8; i++) slv_rd[i*32 +: 32] = slv_val[i];
   end

   for (genvar k = 0; k < 3; k++) begin : g_dut
      mmio_bus_router #(
         .RD_LAT (k == 1 ? 3 : (k == 2 ? 2 : 1)),
         .WR_PROT(k == 1 ? 8'h04 : 8'h00)
      ) u_dut (
         .clk(clk), .rst(rst), .cpu_addr(addr), .cpu_wrdata(wdata), .cpu_memop(memop),
         .cpu_we(we), .cpu_re(re), .cpu_rddata(rdd[k]), .cpu_rdvalid(rdv[k]),
         .slv_addr(saddr[k]), .slv_wrdata(swd[k]), .slv_memop(smop[k]), .slv_we(swe[k]),
         .slv_rddata(slv_rd), .fault_clr(clr), .fault_valid(fv[k]), .fault_addr(fa[k]),
         .fault_is_write(fw[k]), .fault_cnt(fc[k])
      );
   end

   int errs = 0, checks = 0, cyc = 0;

   // Reference model: expected read returns are scheduled by absolute cycle number.
   bit          m_pv [3][8];
   logic [31:0] m_pd [3][8];
   bit          m_fv [3];
   logic [31:0] m_fa [3];
   bit          m_fw [3];
   int          m_fc [3];

   function automatic int region(input logic [31:0] a);
      int p = int'(a[31:20]);
      return (p >= 1 && p <= 8) ? p - 1 : -1;
   endfunction

   function automatic int lat(input int k);
      return (k == 1) ? 3 : ((k == 2) ? 2 : 1);
   endfunction

   function automatic bit prot(input int k, input int r);
      return (k == 1) && (r == 2);
   endfunction

   function automatic logic [7:0] exp_we(input int k);
      int r = region(addr);
      if (rst || !we || r < 0 || prot(k, r)) return 8'h00;
      return 8'(1 << r);
   endfunction

   task automatic model_flush();
      for (int k = 0; k < 3; k++) begin
         for (int s = 0; s < 8; s++) m_pv[k][s] = 1'b0;
         m_fv[k] = 1'b0; m_fa[k] = '0; m_fw[k] = 1'b0; m_fc[k] = 0;
      end
   endtask

   task automatic advance();
      if (rst) model_flush();
      else begin
         for (int k = 0; k < 3; k++) begin
            int r;
            bit ev;
            r = region(addr);
            m_pv[k][cyc % 8] = 1'b0;
            if (re && !we) begin
               m_pv[k][(cyc + lat(k)) % 8] = 1'b1;
               m_pd[k][(cyc + lat(k)) % 8] = (r < 0) ? 32'h0 : slv_val[r];
            end
            ev = (re && !we && r < 0) || (we && (r < 0 || prot(k, r)));
            if (ev && (!m_fv[k] || clr)) begin
               m_fv[k] = 1'b1; m_fa[k] = addr; m_fw[k] = we;
            end else if (clr) m_fv[k] = 1'b0;
            if (clr) m_fc[k] = 0;
            if (ev && m_fc[k] < 65535) m_fc[k]++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                        input bit c);
      we = w; re = r; addr = a; wdata = d; clr = c; memop = 3'($urandom_range(0, 7));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1, 0, 32'h00100000, 32'h12345678, 0);
      #2;
      for (int k = 0; k < 3; k++) begin
         checks++; if (swe[k] !== 8'h00) begin errs++; $display("FAIL reset_we k=%0d got=%h exp=00", k, swe[k]); end
      end
      advance(); advance();
      #2;
      for (int k = 0; k < 3; k++) begin
         checks++; if (rdv[k] !== 1'b0 || rdd[k] !== 32'h0) begin errs++; $display("FAIL reset_rd k=%0d got=%b/%h exp=0/0", k, rdv[k], rdd[k]); end
         checks++; if (fv[k] !== 1'b0 || fa[k] !== 32'h0 || fw[k] !== 1'b0 || fc[k] !== 16'h0) begin
            errs++; $display("FAIL reset_fault k=%0d got=%b/%h/%b/%h exp=0/0/0/0", k, fv[k], fa[k], fw[k], fc[k]);
         end
      end
      drive(0, 0, 32'h0, 32'h0, 0);
      rst = 1'b0;
      advance();
   endtask

   task automatic test_store_load();
      drive(1, 0, 32'h00100010, 32'hDEADBEEF, 0);
      #2;
      for (int k = 0; k < 3; k++) begin
         checks++; if (swe[k] !== 8'h01) begin errs++; $display("FAIL store_we k=%0d got=%h exp=01", k, swe[k]); end
         checks++; if (saddr[k] !== 20'h00010 || swd[k] !== 32'hDEADBEEF || smop[k] !== memop) begin
            errs++; $display("FAIL store_pass k=%0d got=%h/%h/%h exp=00010/deadbeef/%h", k, saddr[k], swd[k], smop[k], memop);
         end
      end
      advance();
      drive(0, 1, 32'h00100010, 32'h0, 0);
      for (int c = 0; c < 5; c++) begin
         #2;
         for (int k = 0; k < 3; k++) begin
            checks++; if (rdv[k] !== m_pv[k][cyc % 8] || rdd[k] !== (m_pv[k][cyc % 8] ? m_pd[k][cyc % 8] : 32'h0)) begin
               errs++; $display("FAIL load_ret k=%0d cyc=%0d got=%b/%h exp=%b/%h", k, cyc, rdv[k], rdd[k], m_pv[k][cyc % 8], m_pd[k][cyc % 8]);
            end
         end
         checks++; if (rdv[0] !== (c == 1) || (c == 1 && rdd[0] !== slv_val[0])) begin
            errs++; $display("FAIL load_lat1 c=%0d got=%b/%h exp=%b/%h", c, rdv[0], rdd[0], c == 1, slv_val[0]);
         end
         advance();
         drive(0, 0, 32'h0, 32'h0, 0);
      end
      checks++; if (fc[0] !== 16'h0) begin errs++; $display("FAIL load_cnt got=%h exp=0", fc[0]); end
   endtask

   task automatic test_pipeline();
      for (int i = 0; i < 8; i++) slv_val[i] = 32'h1000 + i;
      for (int c = 0; c < 9; c++) begin
         if (c < 4) drive(0, 1, {12'(c + 1), 20'($urandom)}, 32'h0, 0);
         else drive(0, 0, 32'h0, 32'h0, 0);
         #2;
         for (int k = 0; k < 3; k++) begin
            checks++; if (rdv[k] !== m_pv[k][cyc % 8] || rdd[k] !== (m_pv[k][cyc % 8] ? m_pd[k][cyc % 8] : 32'h0)) begin
               errs++; $display("FAIL pipe_ret k=%0d cyc=%0d got=%b/%h exp=%b/%h", k, cyc, rdv[k], rdd[k], m_pv[k][cyc % 8], m_pd[k][cyc % 8]);
            end
         end
         checks++; if (rdv[1] !== (c >= 3 && c <= 6) || (c >= 3 && c <= 6 && rdd[1] !== 32'h1000 + c - 3)) begin
            errs++; $display("FAIL pipe_lat3 c=%0d got=%b/%h exp=%b/%h", c, rdv[1], rdd[1], (c >= 3 && c <= 6), 32'h1000 + c - 3);
         end
         advance();
      end
   endtask

   task automatic test_miss();
      for (int c = 0; c < 6; c++) begin
         if (c == 0) drive(0, 1, 32'h00F00000, 32'h0, 0);
         else if (c == 1) drive(0, 1, 32'h00E00004, 32'h0, 0);
         else drive(0, 0, 32'h0, 32'h0, 0);
         #2;
         for (int k = 0; k < 3; k++) begin
            checks++; if (rdv[k] !== m_pv[k][cyc % 8] || rdd[k] !== (m_pv[k][cyc % 8] ? m_pd[k][cyc % 8] : 32'h0)) begin
               errs++; $display("FAIL miss_ret k=%0d cyc=%0d got=%b/%h exp=%b/%h", k, cyc, rdv[k], rdd[k], m_pv[k][cyc % 8], m_pd[k][cyc % 8]);
            end
            checks++; if (fv[k] !== m_fv[k] || fa[k] !== m_fa[k] || fw[k] !== m_fw[k] || fc[k] !== 16'(m_fc[k])) begin
               errs++; $display("FAIL miss_fault k=%0d got=%b/%h/%b/%h exp=%b/%h/%b/%h", k, fv[k], fa[k], fw[k], fc[k], m_fv[k], m_fa[k], m_fw[k], m_fc[k]);
            end
         end
         advance();
      end
      #2;
      checks++; if (fv[0] !== 1'b1 || fa[0] !== 32'h00F00000 || fw[0] !== 1'b0 || fc[0] !== 16'd2) begin
         errs++; $display("FAIL miss_first got=%b/%h/%b/%h exp=1/00f00000/0/2", fv[0], fa[0], fw[0], fc[0]);
      end
   endtask

   task automatic test_prot();
      drive(0, 0, 32'h0, 32'h0, 1);
      advance();
      drive(1, 0, 32'h00300000, 32'hCAFE0001, 0);
      #2;
      checks++; if (swe[1] !== 8'h00 || swe[0] !== 8'h04 || swe[2] !== 8'h04) begin
         errs++; $display("FAIL prot_we got=%h/%h/%h exp=04/00/04", swe[0], swe[1], swe[2]);
      end
      advance();
      drive(0, 1, 32'h00300000, 32'h0, 0);
      #2;
      checks++; if (fv[1] !== 1'b1 || fa[1] !== 32'h00300000 || fw[1] !== 1'b1 || fc[1] !== 16'd1) begin
         errs++; $display("FAIL prot_fault got=%b/%h/%b/%h exp=1/00300000/1/1", fv[1], fa[1], fw[1], fc[1]);
      end
      checks++; if (fv[0] !== 1'b0 || fc[0] !== 16'd0) begin errs++; $display("FAIL prot_nofault got=%b/%h exp=0/0", fv[0], fc[0]); end
      for (int c = 0; c < 5; c++) begin
         advance();
         drive(0, 0, 32'h0, 32'h0, 0);
         #2;
         checks++; if (rdv[1] !== (c == 2) || (c == 2 && rdd[1] !== slv_val[2]) || fc[1] !== 16'd1) begin
            errs++; $display("FAIL prot_load c=%0d got=%b/%h/%h exp=%b/%h/1", c, rdv[1], rdd[1], fc[1], c == 2, slv_val[2]);
         end
      end
      advance();
   endtask

   task automatic test_clr_sat();
      drive(1, 0, 32'h00900000, 32'h0, 1);
      advance();
      drive(0, 0, 32'h0, 32'h0, 0);
      #2;
      for (int k = 0; k < 3; k++) begin
         checks++; if (fv[k] !== 1'b1 || fa[k] !== 32'h00900000 || fw[k] !== 1'b1 || fc[k] !== 16'd1) begin
            errs++; $display("FAIL clr_fault k=%0d got=%b/%h/%b/%h exp=1/00900000/1/1", k, fv[k], fa[k], fw[k], fc[k]);
         end
      end
      for (int n = 0; n < 70000; n++) begin
         drive(n[0], ~n[0], {12'h00A, 20'(n)}, 32'(n), 0);
         advance();
      end
      drive(0, 0, 32'h0, 32'h0, 0);
      #2;
      for (int k = 0; k < 3; k++) begin
         checks++; if (fc[k] !== 16'hFFFF || fa[k] !== 32'h00900000) begin
            errs++; $display("FAIL sat k=%0d got=%h/%h exp=ffff/00900000", k, fc[k], fa[k]);
         end
      end
      drive(0, 0, 32'h0, 32'h0, 1);
      advance();
      drive(0, 0, 32'h0, 32'h0, 0);
      #2;
      for (int k = 0; k < 3; k++) begin
         checks++; if (fv[k] !== 1'b0 || fa[k] !== 32'h00900000 || fw[k] !== 1'b1 || fc[k] !== 16'h0) begin
            errs++; $display("FAIL clr_only k=%0d got=%b/%h/%b/%h exp=0/00900000/1/0", k, fv[k], fa[k], fw[k], fc[k]);
         end
      end
      advance(); advance(); advance();
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) slv_val[i] = $urandom;
      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
               {12'($urandom_range(0, 10)), 20'($urandom)}, $urandom, ($urandom_range(0, 15) == 0));
         #2;
         for (int k = 0; k < 3; k++) begin
            checks++; if (swe[k] !== exp_we(k) || saddr[k] !== addr[19:0] || swd[k] !== wdata) begin
               errs++; $display("FAIL rnd_slv k=%0d cyc=%0d got=%h/%h/%h exp=%h/%h/%h", k, cyc, swe[k], saddr[k], swd[k], exp_we(k), addr[19:0], wdata);
            end
            checks++; if (rdv[k] !== m_pv[k][cyc % 8] || rdd[k] !== (m_pv[k][cyc % 8] ? m_pd[k][cyc % 8] : 32'h0)) begin
               errs++; $display("FAIL rnd_ret k=%0d cyc=%0d got=%b/%h exp=%b/%h", k, cyc, rdv[k], rdd[k], m_pv[k][cyc % 8], m_pd[k][cyc % 8]);
            end
            checks++; if (fv[k] !== m_fv[k] || fa[k] !== m_fa[k] || fw[k] !== m_fw[k] || fc[k] !== 16'(m_fc[k])) begin
               errs++; $display("FAIL rnd_fault k=%0d cyc=%0d got=%b/%h/%b/%h exp=%b/%h/%b/%h", k, cyc, fv[k], fa[k], fw[k], fc[k], m_fv[k], m_fa[k], m_fw[k], m_fc[k]);
            end
         end
         advance();
      end
      drive(0, 0, 32'h0, 32'h0, 0);
      for (int c = 0; c < 4; c++) advance();
   endtask

   task automatic test_reset_flight();
      drive(0, 1, 32'h00200000, 32'h0, 0);
      advance();
      drive(0, 0, 32'h0, 32'h0, 0);
      rst = 1'b1;
      model_flush();
      for (int c = 0; c < 3; c++) begin
         #2;
         for (int k = 0; k < 3; k++) begin
            checks++; if (rdv[k] !== 1'b0 || fv[k] !== 1'b0 || fa[k] !== 32'h0 || fw[k] !== 1'b0 || fc[k] !== 16'h0) begin
               errs++; $display("FAIL flight_rst k=%0d c=%0d got=%b/%b/%h/%b/%h exp=0/0/0/0/0", k, c, rdv[k], fv[k], fa[k], fw[k], fc[k]);
            end
         end
         advance();
      end
      rst = 1'b0;
      drive(0, 1, 32'h00200004, 32'h0, 0);
      for (int c = 0; c < 5; c++) begin
         #2;
         for (int k = 0; k < 3; k++) begin
            checks++; if (rdv[k] !== m_pv[k][cyc % 8] || rdd[k] !== (m_pv[k][cyc % 8] ? m_pd[k][cyc % 8] : 32'h0)) begin
               errs++; $display("FAIL flight_ret k=%0d cyc=%0d got=%b/%h exp=%b/%h", k, cyc, rdv[k], rdd[k], m_pv[k][cyc % 8], m_pd[k][cyc % 8]);
            end
         end
         checks++; if (rdv[2] !== (c == 2) || (c == 2 && rdd[2] !== slv_val[1])) begin
            errs++; $display("FAIL flight_lat2 c=%0d got=%b/%h exp=%b/%h", c, rdv[2], rdd[2], c == 2, slv_val[1]);
         end
         advance();
         drive(0, 0, 32'h0, 32'h0, 0);
      end
   endtask

   initial begin
      rst = 1'b0;
      drive(0, 0, 32'h0, 32'h0, 0);
      for (int i = 0; i < 8; i++) slv_val[i] = 32'hA000_0000 + i;
      model_flush();
      #2;
      test_reset();
      test_store_load();
      test_pipeline();
      test_miss();
      test_prot();
      test_clr_sat();
      test_random();
      test_reset_flight();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
